// File: rtl/generador_carriles.sv
`default_nettype none
// ============================================================================
// Module      : generador_carriles
// Description : Scrolling obstacle-lane generator driven by a Galois LFSR.
//               Optional macro SPEED_UP_EN halves the scroll period every
//               8 spawns down to DIVISOR/8.
// Revision    : 1.0 - initial release
// ============================================================================
module generador_carriles #(
    parameter int                LFSR_W  = 8,
    parameter logic [LFSR_W-1:0] TAPS    = 8'hB8,
    parameter int                COLS    = 3,
    parameter int                SEG_W   = 7,
    parameter int                GAP     = 1,
    parameter int                DIVISOR = 13500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            presente,
    input  logic [SEG_W-1:0]      obstaculo,
    output logic [3:0]            tipo_obs,
    output logic [COLS*SEG_W-1:0] display_obs,
    output logic                  tick,
    output logic [7:0]            obs_count
);
    localparam logic [2:0] c_GAME   = 3'd3;
    localparam logic [2:0] c_PA     = 3'd5;
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SEED   = 2'd1;
    localparam logic [1:0] c_SPAWN  = 2'd2;
    localparam logic [1:0] c_FILL   = 2'd3;
    localparam int         c_CNT_W  = $clog2(DIVISOR + 1);
    localparam int         c_DISP_W = COLS * SEG_W;

    logic [1:0]         r_state, w_state_next;
    logic [LFSR_W-1:0]  r_seed, r_lfsr, w_lfsr_step;
    logic [c_CNT_W-1:0] r_tick_cnt, w_period;
    logic [2:0]         r_gap_cnt;
    logic               r_armed;
    logic               w_is_game, w_is_pa, w_in_game, w_hold, w_leave, w_running;
    logic               w_do_seed, w_do_spawn, w_do_fill;

    assign w_is_game = (presente == c_GAME);
    assign w_is_pa   = (presente == c_PA);
    assign w_in_game = (r_state != c_IDLE);
    assign w_hold    = w_in_game && w_is_pa;
    assign w_leave   = w_in_game && !w_is_game && !w_is_pa;
    assign w_running = (r_state == c_SPAWN) || (r_state == c_FILL);

    // Gated by presente so a departure from GAME on a tick cycle suppresses the shift.
    assign tick = w_is_game && w_running && (r_tick_cnt >= w_period - 1'b1);

`ifdef SPEED_UP_EN
    localparam logic [c_CNT_W-1:0] c_FLOOR = c_CNT_W'(DIVISOR / 8);
    logic [c_CNT_W-1:0] r_period;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= c_CNT_W'(DIVISOR);
        end else if (w_do_seed) begin
            r_period <= c_CNT_W'(DIVISOR);
        end else if (w_do_spawn && obs_count != 8'hFF && obs_count[2:0] == 3'd7) begin
            r_period <= ((r_period >> 1) < c_FLOOR) ? c_FLOOR : (r_period >> 1);
        end
    end
    assign w_period = r_period;
`else
    assign w_period = c_CNT_W'(DIVISOR);
`endif

    always_comb begin
        w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        if (w_lfsr_step == '0) begin
            w_lfsr_step = LFSR_W'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_is_game && r_armed) w_state_next = c_SEED;
            c_SEED:  if (w_is_game) w_state_next = c_SPAWN;
            c_SPAWN: if (tick && GAP > 0) w_state_next = c_FILL;
            c_FILL:  if (tick && r_gap_cnt == 3'(GAP - 1)) w_state_next = c_SPAWN;
            default: w_state_next = c_IDLE;
        endcase
        if (w_leave) begin
            w_state_next = c_IDLE;
        end
    end

    // FSM: outputs (datapath strobes)
    always_comb begin
        w_do_seed  = (r_state == c_SEED) && w_is_game;
        w_do_spawn = tick && (r_state == c_SPAWN);
        w_do_fill  = tick && (r_state == c_FILL);
    end

    // armed stays low after reset until a non-GAME code has been seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seed  <= LFSR_W'(1);
            r_armed <= 1'b0;
        end else if (!w_is_game && !w_hold) begin
            r_seed  <= (r_seed == '1) ? LFSR_W'(1) : r_seed + 1'b1;
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr      <= LFSR_W'(1);
            r_tick_cnt  <= '0;
            r_gap_cnt   <= '0;
            tipo_obs    <= '0;
            display_obs <= '0;
            obs_count   <= '0;
        end else if (w_leave) begin
            display_obs <= '0;
            r_tick_cnt  <= '0;
            r_gap_cnt   <= '0;
        end else if (w_do_seed) begin
            r_lfsr     <= r_seed;
            r_tick_cnt <= '0;
            r_gap_cnt  <= '0;
            obs_count  <= '0;
        end else if (w_do_spawn) begin
            r_tick_cnt  <= '0;
            r_gap_cnt   <= '0;
            display_obs <= {obstaculo, display_obs[c_DISP_W-1:SEG_W]};
            tipo_obs    <= r_lfsr[3:0];
            r_lfsr      <= w_lfsr_step;
            if (obs_count != 8'hFF) begin
                obs_count <= obs_count + 1'b1;
            end
        end else if (w_do_fill) begin
            r_tick_cnt  <= '0;
            r_gap_cnt   <= r_gap_cnt + 1'b1;
            display_obs <= {{SEG_W{1'b0}}, display_obs[c_DISP_W-1:SEG_W]};
        end else if (w_is_game && w_running) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_generador_carriles.sv
`default_nettype none
// ============================================================================
// Module      : tb_generador_carriles
// Description : Directed bench for generador_carriles (DIVISOR=4, GAP=1, COLS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_generador_carriles;
    localparam logic [2:0] c_GAME = 3'd3;
    localparam logic [2:0] c_PA   = 3'd5;
    localparam logic [2:0] c_WLCM = 3'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  presente;
    logic [6:0]  obstaculo;
    logic [3:0]  tipo_obs;
    logic [20:0] display_obs;
    logic        tick;
    logic [7:0]  obs_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    generador_carriles #(
        .LFSR_W (8),
        .TAPS   (8'hB8),
        .COLS   (3),
        .SEG_W  (7),
        .GAP    (1),
        .DIVISOR(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .presente   (presente),
        .obstaculo  (obstaculo),
        .tipo_obs   (tipo_obs),
        .display_obs(display_obs),
        .tick       (tick),
        .obs_count  (obs_count)
    );

    typedef struct {
        logic [6:0]  obst;
        logic [20:0] disp;
        logic [3:0]  tipo;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Returns on the negedge where tick is high; n = negedges waited.
    task automatic wait_tick(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (tick) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout: got no tick required tick within 20 cycles");
        end
    endtask

    initial begin
        int n;
        bit saw_tick;
        bit disp_moved;

        // Expected values: LFSR chain 01->B8->5C->2E->17->B3->E1, columns {entry,mid,exit}
        vecs[0]  = '{7'h7F, 21'h1FC000, 4'h1, 8'd1};
        vecs[1]  = '{7'h7F, 21'h003F80, 4'h1, 8'd1};
        vecs[2]  = '{7'h7F, 21'h1FC07F, 4'h8, 8'd2};
        vecs[3]  = '{7'h7F, 21'h003F80, 4'h8, 8'd2};
        vecs[4]  = '{7'h2A, 21'h0A807F, 4'hC, 8'd3};
        vecs[5]  = '{7'h7F, 21'h001500, 4'hC, 8'd3};
        vecs[6]  = '{7'h55, 21'h15402A, 4'hE, 8'd4};
        vecs[7]  = '{7'h7F, 21'h002A80, 4'hE, 8'd4};
        vecs[8]  = '{7'h01, 21'h004055, 4'h7, 8'd5};
        vecs[9]  = '{7'h7F, 21'h000080, 4'h7, 8'd5};
        vecs[10] = '{7'h40, 21'h100001, 4'h3, 8'd6};

        rst       = 1'b1;
        presente  = 3'd0;
        obstaculo = 7'h0;
        repeat (2) @(negedge clk);
        check("reset_display", 32'(display_obs), 32'h0);
        check("reset_tipo",    32'(tipo_obs),    32'h0);
        check("reset_count",   32'(obs_count),   32'h0);
        check("reset_tick",    32'(tick),        32'h0);

        // GAME straight out of reset must not start the game
        rst      = 1'b0;
        presente = c_GAME;
        saw_tick = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tick) saw_tick = 1'b1;
        end
        check("no_entry_after_reset", 32'(saw_tick), 32'h0);

        // 255 non-GAME cycles wrap the seed counter 1..255 back to 1
        presente = c_WLCM;
        repeat (255) @(negedge clk);
        presente = c_GAME;

        for (int i = 0; i < 11; i++) begin
            obstaculo = vecs[i].obst;
            wait_tick(n);
            check(i == 0 ? "first_tick_latency" : "tick_spacing", 32'(n), i == 0 ? 32'd5 : 32'd3);
            @(negedge clk);
            check($sformatf("vec%0d_display", i), 32'(display_obs), 32'(vecs[i].disp));
            check($sformatf("vec%0d_tipo", i),    32'(tipo_obs),    32'(vecs[i].tipo));
            check($sformatf("vec%0d_count", i),   32'(obs_count),   32'(vecs[i].cnt));
        end

        // Pause for 21 cycles one cycle into a period; phase must be preserved
        obstaculo = 7'h7F;
        @(negedge clk);
        presente   = c_PA;
        saw_tick   = 1'b0;
        disp_moved = 1'b0;
        repeat (21) begin
            @(negedge clk);
            if (tick) saw_tick = 1'b1;
            if (display_obs !== 21'h100001) disp_moved = 1'b1;
        end
        check("pause_tick_low",  32'(saw_tick),   32'h0);
        check("pause_disp_hold", 32'(disp_moved), 32'h0);
        check("pause_tipo_hold", 32'(tipo_obs),   32'h3);
        presente = c_GAME;
        wait_tick(n);
        check("resume_phase", 32'(n), 32'd2);
        @(negedge clk);
        check("resume_display", 32'(display_obs), 32'h002000);

        // WLCM mid-game clears columns next cycle; 4 WLCM cycles move seed 1->5
        presente = c_WLCM;
        @(negedge clk);
        check("wlcm_display", 32'(display_obs), 32'h0);
        check("wlcm_tipo",    32'(tipo_obs),    32'h3);
        check("wlcm_count",   32'(obs_count),   32'd6);
        repeat (3) @(negedge clk);
        presente  = c_GAME;
        obstaculo = 7'h11;
        wait_tick(n);
        check("reseed_latency", 32'(n), 32'd5);
        @(negedge clk);
        check("reseed_display", 32'(display_obs), 32'h044000);
        check("reseed_tipo",    32'(tipo_obs),    32'h5);
        check("reseed_count",   32'(obs_count),   32'd1);

        // Leaving GAME on the tick cycle suppresses the shift
        wait_tick(n);
        check("fill_spacing", 32'(n), 32'd3);
        presente = c_PA;
        #1;
        check("leave_tick_low", 32'(tick), 32'h0);
        @(negedge clk);
        check("leave_no_shift", 32'(display_obs), 32'h044000);
        presente = c_GAME;
        #1;
        check("resume_tick_now", 32'(tick), 32'h1);
        @(negedge clk);
        check("late_fill_display", 32'(display_obs), 32'h000880);

        // Asynchronous reset between clock edges
        rst = 1'b1;
        #1;
        check("async_rst_display", 32'(display_obs), 32'h0);
        check("async_rst_tipo",    32'(tipo_obs),    32'h0);
        check("async_rst_count",   32'(obs_count),   32'h0);
        check("async_rst_tick",    32'(tick),        32'h0);
        #1;
        rst      = 1'b0;
        saw_tick = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (tick) saw_tick = 1'b1;
        end
        check("no_reentry_after_rst", 32'(saw_tick),    32'h0);
        check("post_rst_display",     32'(display_obs), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
